// File: rtl/rob_ctrl.sv
// Purpose: circular reorder buffer that allocates in order, commits in order and walks back squashed entries.
// Latency: writeback is visible to commit one cycle later; a flush is followed by one walk cycle per younger entry.
// Backpressure: alloc_ready drops when the buffer is full, on the flush cycle and during the walk.
module rob_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [4:0]       alloc_rd_log,
    input  logic [5:0]       alloc_rd_phys,
    input  logic [5:0]       alloc_rd_old_phys,
    input  logic             alloc_is_branch,
    input  logic [31:0]      alloc_pc,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             wb_mispredict,
    output logic             commit_valid,
    output logic [4:0]       commit_rd_log,
    output logic [5:0]       commit_rd_phys,
    output logic [5:0]       commit_old_phys,
    output logic [31:0]      commit_pc,
    output logic             flush,
    output logic [31:0]      flush_pc,
    output logic             squash_valid,
    output logic [5:0]       squash_rd_phys,
    output logic [TAG_W:0]   count
);
    typedef enum logic {RUN, WALK} state_t;

    typedef struct packed {
        logic [4:0]  rd_log;
        logic [5:0]  rd_phys;
        logic [5:0]  old_phys;
        logic        is_branch;
        logic [31:0] pc;
    } rob_entry_t;

    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0] ONE_C   = (TAG_W+1)'(1);

    rob_entry_t           ent [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] ent_vld, ent_done, ent_misp;
    logic [TAG_W-1:0]     head, tail, tail_m1;
    state_t               state;
    logic                 out_en;
    logic                 alloc_fire;

    // out_en keeps alloc_ready low while reset is held, so every output reads 0 in reset.
    assign tail_m1      = tail - TAG_W'(1);
    assign commit_valid = (state == RUN) && ent_vld[head] && ent_done[head];
    assign flush        = commit_valid && ent_misp[head];
    assign alloc_ready  = out_en && (state == RUN) && (count != DEPTH_C) && !flush;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign alloc_tag    = tail;
    assign squash_valid = (state == WALK);

    assign commit_rd_log   = commit_valid ? ent[head].rd_log   : '0;
    assign commit_rd_phys  = commit_valid ? ent[head].rd_phys  : '0;
    assign commit_old_phys = commit_valid ? ent[head].old_phys : '0;
    assign commit_pc       = commit_valid ? ent[head].pc       : '0;
    assign flush_pc        = flush        ? ent[head].pc       : '0;
    assign squash_rd_phys  = squash_valid ? ent[tail_m1].rd_phys : '0;

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent[tail] <= '{rd_log:    alloc_rd_log,
                           rd_phys:   alloc_rd_phys,
                           old_phys:  alloc_rd_old_phys,
                           is_branch: alloc_is_branch,
                           pc:        alloc_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld  <= '0;
            ent_done <= '0;
            ent_misp <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= RUN;
            out_en   <= 1'b0;
        end else begin
            out_en <= 1'b1;
            case (state)
                RUN: begin
                    if (wb_valid && ent_vld[wb_tag]) begin
                        ent_done[wb_tag] <= 1'b1;
                        ent_misp[wb_tag] <= wb_mispredict && ent[wb_tag].is_branch;
                    end
                    if (alloc_fire) begin
                        ent_vld[tail]  <= 1'b1;
                        ent_done[tail] <= 1'b0;
                        ent_misp[tail] <= 1'b0;
                        tail           <= tail + 1'b1;
                    end
                    if (commit_valid) begin
                        ent_vld[head] <= 1'b0;
                        head          <= head + 1'b1;
                    end
                    case ({alloc_fire, commit_valid})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                    // Entries younger than the retiring branch must be walked back.
                    if (flush && (count > ONE_C))
                        state <= WALK;
                end
                WALK: begin
                    ent_vld[tail_m1] <= 1'b0;
                    tail             <= tail_m1;
                    count            <= count - 1'b1;
                    if (count == ONE_C)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: a queue-based model checked every cycle plus literal expectations per scenario.
module tb_rob_ctrl;
    logic        clk, rst_n;
    logic        alloc_valid, alloc_ready, alloc_is_branch;
    logic [4:0]  alloc_rd_log;
    logic [5:0]  alloc_rd_phys, alloc_rd_old_phys;
    logic [31:0] alloc_pc;
    logic [3:0]  alloc_tag, wb_tag;
    logic        wb_valid, wb_mispredict;
    logic        commit_valid, flush, squash_valid;
    logic [4:0]  commit_rd_log;
    logic [5:0]  commit_rd_phys, commit_old_phys, squash_rd_phys;
    logic [31:0] commit_pc, flush_pc;
    logic [4:0]  count;

    rob_ctrl #(.ROB_DEPTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd_log(alloc_rd_log), .alloc_rd_phys(alloc_rd_phys),
        .alloc_rd_old_phys(alloc_rd_old_phys), .alloc_is_branch(alloc_is_branch),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_mispredict(wb_mispredict),
        .commit_valid(commit_valid), .commit_rd_log(commit_rd_log),
        .commit_rd_phys(commit_rd_phys), .commit_old_phys(commit_old_phys),
        .commit_pc(commit_pc), .flush(flush), .flush_pc(flush_pc),
        .squash_valid(squash_valid), .squash_rd_phys(squash_rd_phys),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Model: program-order queue of live instructions, oldest at the front.
    typedef struct {
        logic [4:0]  log;
        logic [5:0]  phys;
        logic [5:0]  old;
        logic        br;
        logic [31:0] pc;
        logic        done;
        logic        misp;
        logic [3:0]  tag;
    } m_ent_t;

    m_ent_t     mq[$];
    logic [3:0] mtail = 0;
    bit         mwalk = 0;
    bit         live = 0;
    int         cyc = 0;

    logic [5:0] com_old[$];
    int         com_cyc[$];
    logic [5:0] sq[$];

    always @(negedge clk) begin
        bit e_cv, e_fl, e_ar;
        m_ent_t h, n;
        cyc++;
        if (!rst_n) begin
            chk("rst_alloc_ready", alloc_ready, 0);
            chk("rst_alloc_tag", alloc_tag, 0);
            chk("rst_commit_valid", commit_valid, 0);
            chk("rst_commit_data", {commit_rd_log, commit_rd_phys, commit_old_phys, commit_pc}, 0);
            chk("rst_flush", {flush, flush_pc}, 0);
            chk("rst_squash", {squash_valid, squash_rd_phys}, 0);
            chk("rst_count", count, 0);
            mq.delete();
            mtail = 0;
            mwalk = 0;
            live = 0;
        end else begin
            h = '{default: 0};
            if (mq.size() > 0) h = mq[0];
            e_cv = !mwalk && mq.size() > 0 && h.done;
            e_fl = e_cv && h.misp;
            e_ar = live && !mwalk && mq.size() < 16 && !e_fl;
            chk("alloc_ready", alloc_ready, e_ar);
            chk("alloc_tag", alloc_tag, mtail);
            chk("count", count, mq.size());
            chk("commit_valid", commit_valid, e_cv);
            chk("commit_rd_log", commit_rd_log, e_cv ? h.log : 5'd0);
            chk("commit_rd_phys", commit_rd_phys, e_cv ? h.phys : 6'd0);
            chk("commit_old_phys", commit_old_phys, e_cv ? h.old : 6'd0);
            chk("commit_pc", commit_pc, e_cv ? h.pc : 32'd0);
            chk("flush", flush, e_fl);
            chk("flush_pc", flush_pc, e_fl ? h.pc : 32'd0);
            chk("squash_valid", squash_valid, mwalk);
            chk("squash_rd_phys", squash_rd_phys, mwalk ? mq[$].phys : 6'd0);

            if (commit_valid) begin
                com_old.push_back(commit_old_phys);
                com_cyc.push_back(cyc);
            end
            if (squash_valid) sq.push_back(squash_rd_phys);

            if (mwalk) begin
                void'(mq.pop_back());
                mtail--;
                if (mq.size() == 0) mwalk = 0;
            end else begin
                if (e_cv) void'(mq.pop_front());
                if (wb_valid) begin
                    foreach (mq[i]) begin
                        if (mq[i].tag == wb_tag) begin
                            mq[i].done = 1;
                            mq[i].misp = wb_mispredict && mq[i].br;
                        end
                    end
                end
                if (e_fl && mq.size() > 0) mwalk = 1;
                if (alloc_valid && e_ar) begin
                    n = '{log: alloc_rd_log, phys: alloc_rd_phys, old: alloc_rd_old_phys,
                          br: alloc_is_branch, pc: alloc_pc, done: 0, misp: 0, tag: mtail};
                    mq.push_back(n);
                    mtail++;
                end
            end
            live = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        alloc_valid = 0;
        wb_valid = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic set_alloc(input logic [4:0] lg, input logic [5:0] ph, input logic [5:0] od,
                             input logic br, input logic [31:0] pc);
        alloc_valid = 1;
        alloc_rd_log = lg;
        alloc_rd_phys = ph;
        alloc_rd_old_phys = od;
        alloc_is_branch = br;
        alloc_pc = pc;
    endtask

    task automatic do_alloc(input logic [4:0] lg, input logic [5:0] ph, input logic [5:0] od,
                            input logic br, input logic [31:0] pc);
        set_alloc(lg, ph, od, br, pc);
        tick();
        alloc_valid = 0;
    endtask

    task automatic do_wb(input logic [3:0] tg, input logic mp);
        wb_valid = 1;
        wb_tag = tg;
        wb_mispredict = mp;
        tick();
        wb_valid = 0;
        wb_mispredict = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1;
        alloc_valid = 0; alloc_rd_log = 0; alloc_rd_phys = 0; alloc_rd_old_phys = 0;
        alloc_is_branch = 0; alloc_pc = 0;
        wb_valid = 0; wb_tag = 0; wb_mispredict = 0;

        // 1: reset and first cycle after release
        #2 rst_n = 0;
        #1;
        chk("t1_in_reset_ready", alloc_ready, 0);
        chk("t1_in_reset_count", count, 0);
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        chk("t1_ready", alloc_ready, 1);
        chk("t1_count", count, 0);
        chk("t1_idle", {commit_valid, flush, squash_valid}, 0);

        // 2: out-of-order writeback, in-order commit
        com_old.delete(); com_cyc.delete();
        do_alloc(5'd1, 6'd10, 6'd20, 0, 32'h10);
        do_alloc(5'd2, 6'd11, 6'd21, 0, 32'h14);
        do_alloc(5'd3, 6'd12, 6'd22, 0, 32'h18);
        chk("t2_count3", count, 3);
        do_wb(4'd2, 0);
        chk("t2_no_commit_yet", commit_valid, 0);
        do_wb(4'd0, 0);
        do_wb(4'd1, 0);
        repeat (4) tick();
        chk("t2_ncommits", com_old.size(), 3);
        if (com_old.size() == 3) begin
            chk("t2_old0", com_old[0], 20);
            chk("t2_old1", com_old[1], 21);
            chk("t2_old2", com_old[2], 22);
            chk("t2_c_after_b", com_cyc[2] - com_cyc[1], 1);
        end
        chk("t2_drained", count, 0);

        // 3: full buffer, commit does not free a slot in the same cycle, tag wraps
        do_reset();
        for (int i = 0; i < 16; i++)
            do_alloc(5'(i), 6'(i), 6'(i + 32), 0, 32'h1000 + 32'(4 * i));
        chk("t3_full_count", count, 16);
        chk("t3_full_ready", alloc_ready, 0);
        set_alloc(5'd30, 6'd63, 6'd62, 0, 32'h2000);
        do_wb(4'd0, 0);
        chk("t3_commit", commit_valid, 1);
        chk("t3_commit_old", commit_old_phys, 32);
        chk("t3_still_full", alloc_ready, 0);
        tick();
        chk("t3_count15", count, 15);
        chk("t3_ready_again", alloc_ready, 1);
        chk("t3_wrap_tag", alloc_tag, 0);
        tick();
        alloc_valid = 0;
        chk("t3_refill", count, 16);
        chk("t3_tag_after", alloc_tag, 1);

        // 4: mispredicted branch at head, flush then walk youngest first
        do_reset();
        sq.delete();
        do_alloc(5'd1, 6'd39, 6'd1, 1, 32'h100);
        do_alloc(5'd2, 6'd40, 6'd2, 0, 32'h104);
        do_alloc(5'd3, 6'd41, 6'd3, 0, 32'h108);
        do_alloc(5'd4, 6'd42, 6'd4, 0, 32'h10c);
        do_wb(4'd0, 1);
        chk("t4_flush", flush, 1);
        chk("t4_flush_pc", flush_pc, 32'h100);
        chk("t4_flush_commit", commit_valid, 1);
        chk("t4_flush_noalloc", alloc_ready, 0);
        tick();
        chk("t4_sq42", {squash_valid, squash_rd_phys}, {1'b1, 6'd42});
        tick();
        chk("t4_sq41", {squash_valid, squash_rd_phys}, {1'b1, 6'd41});
        tick();
        chk("t4_sq40", {squash_valid, squash_rd_phys}, {1'b1, 6'd40});
        chk("t4_walk_block", {alloc_ready, commit_valid}, 0);
        tick();
        chk("t4_run_idle", squash_valid, 0);
        chk("t4_count0", count, 0);
        chk("t4_ready", alloc_ready, 1);
        chk("t4_nsquash", sq.size(), 3);

        // 5: reset during the second walk cycle
        do_reset();
        sq.delete();
        do_alloc(5'd1, 6'd50, 6'd1, 1, 32'h200);
        do_alloc(5'd2, 6'd51, 6'd2, 0, 32'h204);
        do_alloc(5'd3, 6'd52, 6'd3, 0, 32'h208);
        do_alloc(5'd4, 6'd53, 6'd4, 0, 32'h20c);
        do_wb(4'd0, 1);
        tick();
        tick();
        chk("t5_walk2", {squash_valid, squash_rd_phys}, {1'b1, 6'd52});
        rst_n = 0;
        #1;
        chk("t5_async_squash", squash_valid, 0);
        chk("t5_async_count", count, 0);
        chk("t5_async_ready", alloc_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        tick();
        chk("t5_post_count", count, 0);
        chk("t5_post_squash", squash_valid, 0);
        chk("t5_nsquash", sq.size(), 1);

        // 6: ignored writebacks and mispredict flag on a non-branch
        do_wb(4'd5, 1);
        chk("t6_empty_wb", {count, commit_valid}, 0);
        do_alloc(5'd7, 6'd17, 6'd27, 0, 32'h300);
        do_alloc(5'd8, 6'd18, 6'd28, 0, 32'h304);
        do_wb(4'd3, 0);
        chk("t6_bad_tag", {count, commit_valid}, {5'd2, 1'b0});
        do_wb(4'd0, 1);
        chk("t6_commit", commit_valid, 1);
        chk("t6_noflush", flush, 0);
        chk("t6_pc", commit_pc, 32'h300);
        tick();
        chk("t6_count", count, 1);
        chk("t6_no_walk", squash_valid, 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
